// File: rtl/alu_seq_param.sv
// alu_seq_param: clocked, width-parametrised ALU with a START/DONE handshake and
// multi-bit shifts run one bit per cycle. Define ALU_ROTATE_EN to enable ROL/ROR (ops 11/12).
module alu_seq_param #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          START,
  input  logic [3:0]    OP,
  input  logic [W-1:0]  INPUTA,
  input  logic [W-1:0]  INPUTB,
  input  logic [SW-1:0] SHAMT,
  output logic          BUSY,
  output logic          DONE,
  output logic [W-1:0]  OUT,
  output logic          SC_OUT,
  output logic          BR_FLAG
);

  localparam logic [3:0] OP_ADDL = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_SRG  = 4'd5;
  localparam logic [3:0] OP_SLG  = 4'd6;
  localparam logic [3:0] OP_SLO  = 4'd7;
  localparam logic [3:0] OP_BL   = 4'd8;
  localparam logic [3:0] OP_BR   = 4'd9;
  localparam logic [3:0] OP_BMH  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

`ifdef ALU_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]    op_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [SW-1:0] cnt_reg;
  logic [W-1:0]  work_reg;
  logic          fill_reg;
  logic [W-1:0]  out_reg;
  logic          sc_reg;
  logic          br_reg;

  logic [W:0]    sum;
  logic [W-1:0]  exec_out;
  logic          exec_sc;
  logic          exec_br;

  logic [W-1:0]  right_val;
  logic [W-1:0]  left_val;
  logic          right_fill;
  logic          left_fill;
  logic          shift_right;
  logic [W-1:0]  step_out;
  logic          step_sc;

  function automatic logic is_shift(input logic [3:0] op);
    is_shift = ((op >= OP_SRA) && (op <= OP_SLO)) ||
               (ROT_EN && ((op == OP_ROL) || (op == OP_ROR)));
  endfunction

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          if (is_shift(OP) && (SHAMT != '0)) begin
            state_next = ST_SHIFT;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC:  state_next = ST_FIN;
      ST_SHIFT: begin
        if (cnt_reg == SW'(1)) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = (state_reg != ST_IDLE);
    DONE = (state_reg == ST_FIN);
  end

  assign OUT     = out_reg;
  assign SC_OUT  = sc_reg;
  assign BR_FLAG = br_reg;

  // Single-cycle result; a shift op only lands in EXEC when its count was zero.
  always_comb begin
    sum      = {1'b0, a_reg} + {1'b0, b_reg} + {{W{1'b0}}, sc_reg};
    exec_out = '0;
    exec_sc  = sc_reg;
    exec_br  = 1'b0;
    if (is_shift(op_reg)) begin
      exec_out = b_reg;
      exec_sc  = 1'b0;
    end else begin
      case (op_reg)
        OP_ADDL: begin
          exec_out = sum[W-1:0];
          exec_sc  = sum[W];
        end
        OP_SUB: begin
          exec_out = a_reg - b_reg;
          exec_sc  = (a_reg < b_reg);
        end
        OP_XOR: begin
          exec_out = a_reg ^ b_reg;
          exec_sc  = 1'b0;
        end
        OP_NOT: begin
          exec_out = ~b_reg;
          exec_sc  = 1'b0;
        end
        OP_BL:   exec_br = ($signed(a_reg) < $signed(b_reg));
        OP_BR:   exec_br = 1'b1;
        OP_BMH:  exec_br = (a_reg[W-1:W/2] == b_reg[W-1:W/2]);
        default: exec_br = 1'b0;
      endcase
    end
  end

  // One-bit shift step: pick direction, the bit entering at the open end and the bit leaving.
  always_comb begin
    right_fill  = 1'b0;
    left_fill   = 1'b0;
    shift_right = 1'b0;
    step_sc     = 1'b0;
    case (op_reg)
      OP_SRA: begin
        right_fill  = work_reg[W-1];
        shift_right = 1'b1;
        step_sc     = work_reg[0];
      end
      OP_SRG: begin
        shift_right = 1'b1;
        step_sc     = work_reg[0];
      end
      OP_SLG: begin
        step_sc = work_reg[W-1];
      end
      OP_SLO: begin
        left_fill = fill_reg;
      end
      OP_ROL: begin
        if (ROT_EN) begin
          left_fill = work_reg[W-1];
          step_sc   = work_reg[W-1];
        end
      end
      OP_ROR: begin
        if (ROT_EN) begin
          right_fill  = work_reg[0];
          shift_right = 1'b1;
          step_sc     = work_reg[0];
        end
      end
      default: begin
        step_sc = 1'b0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_step
      if (gi == W - 1) begin : g_right_msb
        assign right_val[gi] = right_fill;
      end else begin : g_right_mid
        assign right_val[gi] = work_reg[gi+1];
      end
      if (gi == 0) begin : g_left_lsb
        assign left_val[gi] = left_fill;
      end else begin : g_left_mid
        assign left_val[gi] = work_reg[gi-1];
      end
    end
  endgenerate

  assign step_out = shift_right ? right_val : left_val;

  // Operand capture and result registers; results only change on entry to FIN.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt_reg  <= '0;
      work_reg <= '0;
      fill_reg <= 1'b0;
      out_reg  <= '0;
      sc_reg   <= 1'b0;
      br_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            op_reg   <= OP;
            a_reg    <= INPUTA;
            b_reg    <= INPUTB;
            cnt_reg  <= SHAMT;
            work_reg <= INPUTB;
            fill_reg <= sc_reg;
          end
        end
        ST_EXEC: begin
          out_reg <= exec_out;
          sc_reg  <= exec_sc;
          br_reg  <= exec_br;
        end
        ST_SHIFT: begin
          work_reg <= step_out;
          cnt_reg  <= cnt_reg - SW'(1);
          if (cnt_reg == SW'(1)) begin
            out_reg <= step_out;
            sc_reg  <= step_sc;
            br_reg  <= 1'b0;
          end
        end
        default: begin
          fill_reg <= fill_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed and randomized checks of alu_seq_param (W=8) against a
// behavioural model; expectations follow ALU_ROTATE_EN when it is defined.
module tb_alu_seq_param;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

`ifdef ALU_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          Reset;
  logic          START;
  logic [3:0]    OP;
  logic [W-1:0]  INPUTA;
  logic [W-1:0]  INPUTB;
  logic [SW-1:0] SHAMT;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  OUT;
  logic          SC_OUT;
  logic          BR_FLAG;

  int   errors = 0;
  int   checks = 0;
  logic model_sc = 1'b0;

  alu_seq_param #(.W(W), .SW(SW)) dut (
    .CLK(CLK), .Reset(Reset), .START(START), .OP(OP), .INPUTA(INPUTA),
    .INPUTB(INPUTB), .SHAMT(SHAMT), .BUSY(BUSY), .DONE(DONE), .OUT(OUT),
    .SC_OUT(SC_OUT), .BR_FLAG(BR_FLAG)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: whole-operation arithmetic, not per-step.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int sh, input logic sc_in, output logic [W-1:0] o,
                       output logic sc, output logic br, output int lat);
    logic [W:0] s;
    logic shift_op;
    shift_op = (op >= 4 && op <= 7) || (ROT && (op == 11 || op == 12));
    o = '0; sc = sc_in; br = 1'b0; lat = 2;
    if (shift_op && sh == 0) begin
      o = b; sc = 1'b0;
    end else begin
      if (shift_op) lat = sh + 1;
      case (op)
        4'd0: begin s = a + b + sc_in; o = s[W-1:0]; sc = s[W]; end
        4'd1: begin o = a - b; sc = (a < b); end
        4'd2: begin o = a ^ b; sc = 1'b0; end
        4'd3: begin o = ~b; sc = 1'b0; end
        4'd4: begin o = $signed(b) >>> sh; sc = b[sh-1]; end
        4'd5: begin o = b >> sh; sc = b[sh-1]; end
        4'd6: begin o = b << sh; sc = b[W-sh]; end
        4'd7: begin o = (b << sh) | (sc_in ? W'((1 << sh) - 1) : '0); sc = 1'b0; end
        4'd8: br = ($signed(a) < $signed(b));
        4'd9: br = 1'b1;
        4'd10: br = ((a >> (W/2)) == (b >> (W/2)));
        4'd11: if (ROT) begin o = (b << sh) | (b >> (W - sh)); sc = o[0]; end
        4'd12: if (ROT) begin o = (b >> sh) | (b << (W - sh)); sc = o[W-1]; end
        default: ;
      endcase
    end
  endtask

  // Drives one transaction, scrambles inputs after accept and reports what the DUT did.
  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int sh, output int lat, output logic [W-1:0] o,
                          output logic sc, output logic br, output logic busy_ok,
                          output logic idle_after);
    @(negedge CLK);
    START = 1'b1; OP = op; INPUTA = a; INPUTB = b; SHAMT = SW'(sh);
    @(negedge CLK);
    START = 1'b0; OP = 4'($urandom); INPUTA = W'($urandom); INPUTB = W'($urandom);
    SHAMT = SW'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (DONE !== 1'b1 && lat < 40) begin
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      @(negedge CLK);
      lat++;
    end
    if (BUSY !== 1'b1) busy_ok = 1'b0;
    o = OUT; sc = SC_OUT; br = BR_FLAG;
    @(negedge CLK);
    idle_after = (DONE === 1'b0) && (BUSY === 1'b0) && (OUT === o);
    $display("txn op=%0d a=%h b=%h sh=%0d -> out=%h sc=%b br=%b lat=%0d busy_ok=%b idle_after=%b",
             op, a, b, sh, o, sc, br, lat, busy_ok, idle_after);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++;
      $display("FAIL reset_hs: busy=%b done=%b want 0 0", BUSY, DONE); end
    checks++; if (OUT !== '0) begin errors++; $display("FAIL reset_out: got %h want 00", OUT); end
    checks++; if (SC_OUT !== 1'b0 || BR_FLAG !== 1'b0) begin errors++;
      $display("FAIL reset_flags: sc=%b br=%b want 0 0", SC_OUT, BR_FLAG); end
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || OUT !== '0) begin errors++;
      $display("FAIL reset_idle: busy=%b done=%b out=%h want 0 0 00", BUSY, DONE, OUT); end
    model_sc = 1'b0;
  endtask

  task automatic test_carry();
    int lat; logic [W-1:0] o; logic sc, br, bok, idl;
    drive_op(4'd0, 8'hF0, 8'h20, 0, lat, o, sc, br, bok, idl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL carry1_lat: got %0d want 2", lat); end
    checks++; if (o !== 8'h10 || sc !== 1'b1) begin errors++;
      $display("FAIL carry1_res: out=%h sc=%b want 10 1", o, sc); end
    drive_op(4'd0, 8'h01, 8'h01, 0, lat, o, sc, br, bok, idl);
    checks++; if (o !== 8'h03 || sc !== 1'b0 || br !== 1'b0) begin errors++;
      $display("FAIL carry2_res: out=%h sc=%b br=%b want 03 0 0", o, sc, br); end
    checks++; if (!bok || !idl) begin errors++;
      $display("FAIL carry2_hs: busy_ok=%b idle_after=%b want 1 1", bok, idl); end
    model_sc = 1'b0;
  endtask

  task automatic test_shift();
    int lat; logic [W-1:0] o; logic sc, br, bok, idl;
    drive_op(4'd4, 8'h5A, 8'h94, 3, lat, o, sc, br, bok, idl);
    checks++; if (lat !== 4 || !bok) begin errors++;
      $display("FAIL sra_timing: lat=%0d busy_ok=%b want 4 1", lat, bok); end
    checks++; if (o !== 8'hF2 || sc !== 1'b1) begin errors++;
      $display("FAIL sra_res: out=%h sc=%b want f2 1", o, sc); end
    checks++; if (!idl) begin errors++; $display("FAIL sra_after: idle_after=%b want 1", idl); end
    drive_op(4'd6, 8'h00, 8'h81, 0, lat, o, sc, br, bok, idl);
    checks++; if (lat !== 2 || o !== 8'h81 || sc !== 1'b0) begin errors++;
      $display("FAIL slg0: lat=%0d out=%h sc=%b want 2 81 0", lat, o, sc); end
    model_sc = 1'b0;
  endtask

  task automatic test_branch();
    logic [3:0] ops [5] = '{4'd8, 4'd8, 4'd10, 4'd10, 4'd9};
    logic [W-1:0] as [5] = '{8'hFE, 8'h05, 8'h3A, 8'h3A, 8'h77};
    logic [W-1:0] bs [5] = '{8'h01, 8'h03, 8'h35, 8'h45, 8'h11};
    logic exp_br [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat; logic [W-1:0] o; logic sc, br, bok, idl;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], as[i], bs[i], $urandom_range(0, W-1), lat, o, sc, br, bok, idl);
      checks++; if (br !== exp_br[i]) begin errors++;
        $display("FAIL branch%0d_flag: got %b want %b", i, br, exp_br[i]); end
      checks++; if (o !== '0 || sc !== model_sc || lat !== 2) begin errors++;
        $display("FAIL branch%0d_side: out=%h sc=%b lat=%0d want 00 %b 2", i, o, sc, lat, model_sc); end
    end
  endtask

  task automatic test_handshake();
    int done_cnt, done_cyc, lat; logic [W-1:0] o_seen, o; logic sc_seen, sc, br, bok, idl;
    @(negedge CLK);
    START = 1'b1; OP = 4'd5; INPUTA = W'($urandom); INPUTB = 8'hF0; SHAMT = SW'(5);
    @(negedge CLK);
    START = 1'b0;
    done_cnt = 0; done_cyc = -1; o_seen = '0; sc_seen = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (DONE === 1'b1) begin done_cnt++; done_cyc = c; o_seen = OUT; sc_seen = SC_OUT; end
      START = (c == 2 || c == 4 || c == 6);
      OP = 4'($urandom); INPUTB = W'($urandom); SHAMT = SW'($urandom);
      @(negedge CLK);
    end
    $display("txn SRG b=f0 sh=5 with START pulses -> dones=%0d at cycle %0d out=%h sc=%b",
             done_cnt, done_cyc, o_seen, sc_seen);
    checks++; if (done_cnt !== 1 || done_cyc !== 6) begin errors++;
      $display("FAIL hs_done: count=%0d cycle=%0d want 1 6", done_cnt, done_cyc); end
    checks++; if (o_seen !== 8'h07 || sc_seen !== 1'b1) begin errors++;
      $display("FAIL hs_res: out=%h sc=%b want 07 1", o_seen, sc_seen); end
    // Abort an SRG by 7 in its third cycle.
    START = 1'b1; OP = 4'd5; INPUTB = 8'hFF; SHAMT = SW'(7);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b1;
    #1;
    $display("txn reset at cycle 3 of SRG sh=7 -> busy=%b done=%b out=%h sc=%b br=%b",
             BUSY, DONE, OUT, SC_OUT, BR_FLAG);
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || OUT !== '0 || SC_OUT !== 1'b0 || BR_FLAG !== 1'b0)
      begin errors++; $display("FAIL abort_outputs: busy=%b done=%b out=%h sc=%b br=%b want all 0",
                               BUSY, DONE, OUT, SC_OUT, BR_FLAG); end
    @(negedge CLK);
    Reset = 1'b0;
    model_sc = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (DONE === 1'b1 || BUSY === 1'b1) done_cnt++;
      @(negedge CLK);
    end
    checks++; if (done_cnt !== 0) begin errors++;
      $display("FAIL abort_nodone: active cycles=%0d want 0", done_cnt); end
    drive_op(4'd0, 8'h10, 8'h22, 0, lat, o, sc, br, bok, idl);
    checks++; if (o !== 8'h32 || sc !== 1'b0 || lat !== 2 || !bok || !idl) begin errors++;
      $display("FAIL after_reset: out=%h sc=%b lat=%0d hs=%b%b want 32 0 2 11", o, sc, lat, bok, idl); end
  endtask

  task automatic test_slo();
    int lat; logic [W-1:0] o; logic sc, br, bok, idl;
    drive_op(4'd1, 8'h00, 8'h01, 0, lat, o, sc, br, bok, idl);
    checks++; if (o !== 8'hFF || sc !== 1'b1) begin errors++;
      $display("FAIL sub_borrow: out=%h sc=%b want ff 1", o, sc); end
    drive_op(4'd7, 8'h00, 8'h00, 3, lat, o, sc, br, bok, idl);
    checks++; if (o !== 8'h07 || sc !== 1'b0 || lat !== 4) begin errors++;
      $display("FAIL slo_fill: out=%h sc=%b lat=%0d want 07 0 4", o, sc, lat); end
    model_sc = 1'b0;
  endtask

  task automatic test_rotate();
    int lat; logic [W-1:0] o, exp_o; logic sc, br, bok, idl, exp_sc;
    exp_o = ROT ? 8'h03 : 8'h00;
    exp_sc = ROT ? 1'b1 : model_sc;
    drive_op(4'd11, 8'h00, 8'h81, 1, lat, o, sc, br, bok, idl);
    checks++; if (o !== exp_o || sc !== exp_sc || br !== 1'b0 || lat !== 2) begin errors++;
      $display("FAIL rol: out=%h sc=%b br=%b lat=%0d want %h %b 0 2", o, sc, br, lat, exp_o, exp_sc); end
    model_sc = exp_sc;
  endtask

  task automatic test_random();
    int lat, elat, sh; logic [W-1:0] a, b, o, eo; logic [3:0] op; logic sc, br, bok, idl, esc, ebr;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a = W'($urandom); b = W'($urandom);
      sh = $urandom_range(0, W-1);
      model(op, a, b, sh, model_sc, eo, esc, ebr, elat);
      drive_op(op, a, b, sh, lat, o, sc, br, bok, idl);
      checks++; if (o !== eo) begin errors++;
        $display("FAIL rnd%0d_out: op=%0d got %h want %h", i, op, o, eo); end
      checks++; if (sc !== esc || br !== ebr) begin errors++;
        $display("FAIL rnd%0d_flags: op=%0d sc=%b br=%b want %b %b", i, op, sc, br, esc, ebr); end
      checks++; if (lat !== elat || !bok || !idl) begin errors++;
        $display("FAIL rnd%0d_hs: op=%0d lat=%0d busy_ok=%b idle_after=%b want %0d 1 1",
                 i, op, lat, bok, idl, elat); end
      model_sc = esc;
    end
  endtask

  initial begin
    Reset = 1'b1; START = 1'b0; OP = '0; INPUTA = '0; INPUTB = '0; SHAMT = '0;
    test_reset();
    test_carry();
    test_shift();
    test_branch();
    test_handshake();
    test_slo();
    test_rotate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised, clocked successor to the datapath ALU. It extends the original 8-bit combinational opcode set in three ways: configurable width W, an internal carry/shift register, and multi-bit shifts executed one bit per cycle. The block sits between the register file and the branch/writeback logic and uses a START/DONE handshake under control of the sequencer.

Parameters:
W, 8, datapath width in bits (even, >= 4)
SW, $clog2(W), width of the shift-amount field

Ports:
CLK  input  1  clock
Reset  input  1  asynchronous, active-high reset
START  input  1  one-cycle request; accepted only in IDLE
OP  input  4  opcode, captured on accept
INPUTA  input  W  operand A (signed), captured on accept
INPUTB  input  W  operand B (signed), captured on accept
SHAMT  input  SW  shift count for shift opcodes, captured on accept
BUSY  output  1  high from the cycle after accept until the DONE cycle, inclusive
DONE  output  1  one-cycle pulse when results are valid
OUT  output  W  result; registered, held until the next DONE
SC_OUT  output  1  internal carry/shift register (SC_REG)
BR_FLAG  output  1  branch decision; registered, held until the next DONE

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high, on port Reset.
- Reset values:
  - State = IDLE.
  - OUT, SC_OUT, BR_FLAG, BUSY and DONE all = 0.
  - Reset mid-operation aborts the operation. No DONE is produced.
- States:
  - IDLE: START=1 captures OP, INPUTA, INPUTB and SHAMT. Go to EXEC if the op is non-shift or SHAMT=0; otherwise go to SHIFT with count = SHAMT.
  - EXEC: compute the result, then go to FIN.
  - SHIFT: one bit per cycle; decrement count; go to FIN after the last step.
  - FIN: DONE=1 for one cycle, then go to IDLE.
- Latency (accept at cycle 0):
  - DONE at cycle 2 for non-shift ops and for SHAMT=0.
  - DONE at cycle SHAMT+1 for shifts.
- START while not in IDLE is ignored. Input changes after accept are ignored.
- Opcodes:
  - 0 ADDL: {SC,OUT} = A + B + SC_REG.
  - 1 SUB: OUT = A - B; SC = 1 iff A < B unsigned (borrow).
  - 2 XOR: OUT = A ^ B; SC = 0.
  - 3 NOT: OUT = ~B; SC = 0.
  - 4 SRA, per step: SC = bit0; shift right arithmetic.
  - 5 SRG, per step: SC = bit0; shift right logical.
  - 6 SLG, per step: SC = bit W-1; shift left, fill 0.
  - 7 SLO, per step: shift left, filling with SC_REG as sampled at accept; SC = 0 at end.
  - 8 BL: BR_FLAG = (A < B) signed compare, evaluated on true signed comparison.
  - 9 BR: BR_FLAG = 1.
  - 10 BMH: BR_FLAG = 1 iff A[W-1:W/2] == B[W-1:W/2].
  - Others: NOP.
- Results of non-updating ops:
  - Ops 8–15: OUT = 0 and SC_REG unchanged.
  - Ops 0–7: BR_FLAG = 0.
- Shift with SHAMT=0: OUT = B; SC_REG cleared.
- All arithmetic is modulo 2^W. The carry is bit W of the (W+1)-bit sum.

Optional Feature:
- Macro: ALU_ROTATE_EN.
- Defined:
  - Opcode 11 ROL: multi-cycle rotate left by SHAMT. SC = the last bit moved from MSB to LSB.
  - Opcode 12 ROR: multi-cycle rotate right by SHAMT. SC = the last bit moved from LSB to MSB.
  - Both use the same SHIFT state and the same latency as the other shifts.
- Undefined: opcodes 11 and 12 execute as NOP (OUT = 0, BR_FLAG = 0, SC_REG unchanged, DONE at cycle 2).

Test Plan:
1. Carry chain, W=8:
   - ADDL A=0xF0, B=0x20 after reset -> DONE at cycle 2, OUT=0x10, SC_OUT=1.
   - Then ADDL A=0x01, B=0x01 -> OUT=0x03, SC_OUT=0.
2. Multi-cycle shift: SRA B=0x94, SHAMT=3 -> BUSY for cycles 1–4, DONE at cycle 4, OUT=0xF2, SC_OUT=1.
   - Then SLG B=0x81, SHAMT=0 -> DONE at cycle 2, OUT=0x81, SC_OUT=0.
3. Branch ops:
   - BL A=0xFE, B=0x01 -> BR_FLAG=1.
   - BL A=0x05, B=0x03 -> BR_FLAG=0.
   - BMH A=0x3A, B=0x35 -> BR_FLAG=1.
   - BMH A=0x3A, B=0x45 -> BR_FLAG=0.
   - BR -> BR_FLAG=1.
4. Handshake and reset:
   - START pulses during an SRG with SHAMT=5 -> ignored; exactly one DONE is produced.
   - Reset asserted at cycle 3 of an SRG with SHAMT=7 -> all outputs 0 immediately, no DONE.
   - Next START after reset completes normally.
5. SLO fill: SUB A=0x00, B=0x01 (sets SC=1) -> then SLO B=0x00, SHAMT=3 -> OUT=0x07, SC_OUT=0.
6. Rotate, ALU_ROTATE_EN defined: ROL B=0x81, SHAMT=1 -> OUT=0x03, SC_OUT=1.
   - Same stimulus with the macro undefined -> OUT=0x00, DONE at cycle 2.
